// File: rtl/byte_word_packer.sv
// byte_word_packer
// Collects consecutive ingress bytes into one little-endian word of BYTES
// lanes and presents it on a registered valid/ready egress. A byte flagged
// last closes a short word early. Lanes that were not filled read zero on
// both data and keep.
module byte_word_packer #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid_i,
  input  logic [7:0]         i_data_i,
  input  logic               i_last_i,
  output logic               i_ready_o,
  input  logic               e_ready_i,
  output logic               e_valid_o,
  output logic [8*BYTES-1:0] e_data_o,
  output logic [BYTES-1:0]   e_keep_o,
  output logic               e_last_o
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(BYTES - 1);

  logic [CW-1:0]        r_cnt;
  logic [8*BYTES-1:0]   r_acc;
  logic [BYTES-1:0]     r_keep_acc;
  logic                 r_valid;
  logic [8*BYTES-1:0]   r_data;
  logic [BYTES-1:0]     r_keep;
  logic                 r_last;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_complete;
  logic [8*BYTES-1:0]   w_acc_new;
  logic [BYTES-1:0]     w_keep_new;

  // Ready only looks at the egress slot: free, or being drained this cycle.
  assign w_ready    = !r_valid || e_ready_i;
  assign w_accept   = i_valid_i && w_ready;
  assign w_pop      = r_valid && e_ready_i;
  assign w_complete = w_accept && ((r_cnt == LAST_LANE) || i_last_i);

  // Accumulator and keep mask with the incoming byte merged into lane r_cnt.
  always_comb begin
    w_acc_new  = r_acc;
    w_keep_new = r_keep_acc;
    w_acc_new[int'(r_cnt)*8 +: 8] = i_data_i;
    w_keep_new[r_cnt]             = 1'b1;
  end

  // Lane counter and partial-word accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_keep_acc <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt      <= '0;
        r_acc      <= '0;
        r_keep_acc <= '0;
      end else begin
        r_cnt      <= r_cnt + CW'(1);
        r_acc      <= w_acc_new;
        r_keep_acc <= w_keep_new;
      end
    end
  end

  // Egress register: a completing byte always wins, since it is only
  // accepted when the slot is empty or being popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (w_complete) begin
      r_valid <= 1'b1;
      r_data  <= w_acc_new;
      r_keep  <= w_keep_new;
      r_last  <= i_last_i;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign i_ready_o = w_ready;
  assign e_valid_o = r_valid;
  assign e_data_o  = r_data;
  assign e_keep_o  = r_keep;
  assign e_last_o  = r_last;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer (BYTES=4): a fixed vector table for the basic
// packing cases, hand sequences for stall and mid-word reset, and a random
// run. A bench-side model pushes each completed word onto a queue; the head
// of the queue must match whatever the DUT presents.
module tb_byte_word_packer;

  localparam int B = 4;
  localparam int W = 8 * B;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid_i = 1'b0;
  logic [7:0]   i_data_i = 8'h00;
  logic         i_last_i = 1'b0;
  logic         i_ready_o;
  logic         e_ready_i = 1'b0;
  logic         e_valid_o;
  logic [W-1:0] e_data_o;
  logic [B-1:0] e_keep_o;
  logic         e_last_o;

  byte_word_packer #(.BYTES(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid_i (i_valid_i),
    .i_data_i  (i_data_i),
    .i_last_i  (i_last_i),
    .i_ready_o (i_ready_o),
    .e_ready_i (e_ready_i),
    .e_valid_o (e_valid_o),
    .e_data_o  (e_data_o),
    .e_keep_o  (e_keep_o),
    .e_last_o  (e_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [B-1:0] keep;
    logic         last;
  } word_t;

  typedef struct {
    logic         valid;
    logic [7:0]   data;
    logic         last;
    logic         eready;
    logic         x_valid;
    logic [W-1:0] x_data;
    logic [B-1:0] x_keep;
    logic         x_last;
  } vec_t;

  word_t        q[$];
  int           m_cnt;
  logic [W-1:0] m_acc;
  logic [B-1:0] m_keep;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt  = 0;
    m_acc  = '0;
    m_keep = '0;
  endtask

  // One clock cycle: drive at negedge, check DUT against the model, then
  // advance the model as the coming posedge will.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic exp_ready;
    logic pop;
    logic acc;
    @(negedge clk);
    i_valid_i = v;
    i_data_i  = d;
    i_last_i  = l;
    e_ready_i = r;
    #1;
    exp_ready = (q.size() == 0) || r;
    chk("i_ready_o", 64'(i_ready_o), 64'(exp_ready));
    chk("e_valid_o", 64'(e_valid_o), 64'(q.size() != 0));
    if (q.size() != 0 && e_valid_o) begin
      chk("e_data_o", 64'(e_data_o), 64'(q[0].data));
      chk("e_keep_o", 64'(e_keep_o), 64'(q[0].keep));
      chk("e_last_o", 64'(e_last_o), 64'(q[0].last));
    end
    pop = (q.size() != 0) && r;
    acc = v && exp_ready;
    if (pop) void'(q.pop_front());
    if (acc) begin
      m_acc[m_cnt*8 +: 8] = d;
      m_keep[m_cnt]       = 1'b1;
      if (m_cnt == B - 1 || l) begin
        q.push_back('{data: m_acc, keep: m_keep, last: l});
        m_cnt  = 0;
        m_acc  = '0;
        m_keep = '0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    i_valid_i = 1'b0;
    i_last_i  = 1'b0;
    e_ready_i = 1'b0;
    #1;
    chk("rst e_valid_o", 64'(e_valid_o), 64'd0);
    chk("rst e_data_o",  64'(e_data_o),  64'd0);
    chk("rst e_keep_o",  64'(e_keep_o),  64'd0);
    chk("rst e_last_o",  64'(e_last_o),  64'd0);
    chk("rst i_ready_o", 64'(i_ready_o), 64'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[14];

  initial begin
    // Outputs expected during each row, i.e. before that row's clock edge.
    vecs[0]  = '{1, 8'h11, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[1]  = '{1, 8'h22, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[2]  = '{1, 8'h33, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[3]  = '{1, 8'h44, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[4]  = '{1, 8'h55, 0, 1, 1, 32'h44332211, 4'hF, 0};
    vecs[5]  = '{1, 8'h66, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[6]  = '{1, 8'h77, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[7]  = '{1, 8'h88, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[8]  = '{1, 8'hAA, 0, 1, 1, 32'h88776655, 4'hF, 0};
    vecs[9]  = '{1, 8'hBB, 0, 1, 0, 32'h0, 4'h0, 0};
    vecs[10] = '{1, 8'hCC, 1, 1, 0, 32'h0, 4'h0, 0};
    vecs[11] = '{1, 8'h5A, 1, 1, 1, 32'h00CCBBAA, 4'h7, 1};
    vecs[12] = '{0, 8'h00, 0, 1, 1, 32'h0000005A, 4'h1, 1};
    vecs[13] = '{0, 8'h00, 0, 1, 0, 32'h0, 4'h0, 0};

    model_clear();
    do_reset();

    // Basic packing, short word, single-byte word landing in lane 0.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].eready);
      chk($sformatf("vec%0d valid", i), 64'(e_valid_o), 64'(vecs[i].x_valid));
      if (vecs[i].x_valid) begin
        chk($sformatf("vec%0d data", i), 64'(e_data_o), 64'(vecs[i].x_data));
        chk($sformatf("vec%0d keep", i), 64'(e_keep_o), 64'(vecs[i].x_keep));
        chk($sformatf("vec%0d last", i), 64'(e_last_o), 64'(vecs[i].x_last));
      end
    end

    // Stall: word held for 5 cycles with bytes offered but refused.
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h04, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h05, 0, 0);
      chk("stall i_ready_o", 64'(i_ready_o), 64'd0);
      chk("stall data", 64'(e_data_o), 64'h04030201);
    end
    step(1, 8'h05, 0, 1);
    step(1, 8'h06, 0, 1);
    step(1, 8'h07, 0, 1);
    step(1, 8'h08, 1, 1);
    step(0, 8'h00, 0, 1);
    chk("post-stall data", 64'(e_data_o), 64'h08070605);
    chk("post-stall last", 64'(e_last_o), 64'd1);
    step(0, 8'h00, 0, 1);

    // Reset after two bytes; the next four bytes form a fresh word.
    step(1, 8'hE1, 0, 1);
    step(1, 8'hE2, 0, 1);
    do_reset();
    step(1, 8'hD1, 0, 1);
    step(1, 8'hD2, 0, 1);
    step(1, 8'hD3, 0, 1);
    step(1, 8'hD4, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("post-reset data", 64'(e_data_o), 64'hD4D3D2D1);
    chk("post-reset keep", 64'(e_keep_o), 64'hF);
    step(0, 8'h00, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) < 6);
    end
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("drain empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
